regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the Otter single-write/dual-read register file, for the pipelined core.
- Adds N read ports, write-through bypass and a per-register busy scoreboard for hazard detection.
- Adds a post-reset clear sweep so the storage array needs no reset and stays RAM-inferable.
- Sits between decode (reads, reservations) and writeback (writes, busy release). Everything is on the rising clock edge; there is no negedge write.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, register count; power of two, at least 2.
- NREAD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle writeback is forwarded to matching read ports.
- AW, $clog2(NREGS), address width (derived localparam).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-high reset.
- ready  out  1  high once the clear sweep finishes; writes and reservations are ignored while low.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data, combinational.
- rd_busy  out  NREAD  per port: source register has a pending writeback.
- rsv_en  in  1  reserve destination register (instruction issued).
- rsv_addr  in  AW  register to mark busy.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register.
- wb_data  in  XLEN  writeback value.

Behaviour:
- Reset (async, rst=1): FSM enters CLEAR, sweep counter = 0, every busy bit = 0, ready = 0. Array contents are not reset.
- FSM CLEAR: each cycle writes 0 to array[cnt] and increments cnt. After cnt == NREGS-1 is written, the FSM goes to RUN and ready = 1. The sweep takes exactly NREGS cycles after rst deasserts.
- FSM RUN: stays there until the next rst. There are no other transitions.
- rst asserted mid-sweep: the sweep restarts from 0.
- Register 0 is hardwired:
  - reads of address 0 return 0;
  - writes and reservations to address 0 are ignored;
  - busy[0] is always 0.
- Write (RUN, wb_en=1, wb_addr!=0): array[wb_addr] <= wb_data at the edge, visible through the array on the next cycle. busy[wb_addr] clears at the same edge.
- Read, port i (combinational):
  - if rd_addr_i == 0: rd_data_i = 0;
  - else if BYPASS && ready && wb_en && wb_addr == rd_addr_i: rd_data_i = wb_data;
  - else: rd_data_i = array[rd_addr_i].
- Reads return undefined data while ready=0; consumers must stall.
- rd_busy_i = busy[rd_addr_i] & ~(BYPASS && ready && wb_en && wb_addr == rd_addr_i). Matching the bypass condition lets a consumer issue in the same cycle the producer writes back.
- Reserve (RUN, rsv_en=1, rsv_addr!=0): busy[rsv_addr] <= 1.
- Reserve and writeback to the same register in the same cycle: the reservation wins, so the busy bit ends at 1 (new producer). The data is still written.
- Reserving an already-busy register: busy stays 1. A single bit, not a counter; the pipeline issues in order.
- Writeback to a non-busy register: data is written and busy stays 0. This is not an error.
- wb_en or rsv_en while ready=0: dropped, with no side effects.
- All NREAD ports are independent; duplicate addresses across ports are legal.

Decomposition:
- Package otter_rf_pkg holds:
  - default XLEN/NREGS constants;
  - the FSM enum rf_state_t {RF_CLEAR, RF_RUN};
  - a function that extracts field i from a packed port vector.
- Sub-module rf_scoreboard holds the NREGS busy bits, the reserve/release logic with reserve-wins priority, and the per-port busy lookup with bypass masking. It takes clk, rst, ready and the same rsv/wb/rd_addr signals.
- The storage array, clear FSM and read muxing stay in regfile_mp.

Test Plan:
- Reset sweep: pulse rst, deassert, hold wb_en=1 (addr 5, data 0xDEAD). Required: ready=0 for exactly 32 cycles then 1; reading addr 5 then returns 0, because the write during the sweep was dropped.
- Write/readback and x0:
  - write 0x1234_5678 to r7, then on the next cycle read r7 on both ports: 0x1234_5678 on both;
  - write 0xFFFF_FFFF to r0, then read r0: returns 0.
- Bypass: in one cycle wb_en=1 (r9, 0xCAFE_F00D) with rd_addr0=9. Required: rd_data0=0xCAFE_F00D in that same cycle and rd_busy0=0. With BYPASS=0 the bench instead expects the old value (0) and busy unmasked.
- Scoreboard:
  - reserve r3; next cycle rd_addr1=3 gives rd_busy1=1;
  - writeback r3 (0x55) clears busy at that edge; the following cycle rd_busy1=0 and data=0x55.
- Simultaneous: rsv_en and wb_en both on r4 (data 0x77) in one cycle. Required next cycle: busy[4]=1 and array[4]=0x77. Reserving r0 leaves rd_busy=0.
- Mid-sweep reset plus parameter sweep: assert rst at sweep cycle 10; ready must stay low for a full NREGS cycles after release. Rerun the suite with NREGS=16, NREAD=4, XLEN=64.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// Shared constants, FSM encoding and packed-port helpers for the multi-port register file.
package otter_rf_pkg;

    localparam int unsigned RF_XLEN     = 32;
    localparam int unsigned RF_NREGS    = 32;
    localparam int unsigned FIELD_VEC_W = 256;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    // Returns field i (w bits wide, w <= 64) of a packed port vector, zero-extended.
    function automatic logic [63:0] field_get(
        input logic [FIELD_VEC_W-1:0] vec,
        input int unsigned            w,
        input int unsigned            i
    );
        logic [FIELD_VEC_W-1:0] sh;
        logic [63:0]            mask;
        sh   = vec >> (i * w);
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return sh[63:0] & mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on reservation, cleared on writeback, looked up per read port.
module rf_scoreboard
    import otter_rf_pkg::*;
#(
    parameter  int unsigned NREGS  = RF_NREGS,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]  rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             fwd_en;
    logic [AW-1:0]    ra;

    assign fwd_en = (BYPASS != 0) && ready && wb_en;

    // Release first so a same-cycle reservation of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            if (wb_en) begin
                busy_d[wb_addr] = 1'b0;
            end
            if (rsv_en) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        ra      = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra         = AW'(field_get(FIELD_VEC_W'(rd_addr), AW, i));
            rd_busy[i] = busy_q[ra] & ~(fwd_en && (wb_addr == ra));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, busy scoreboard and post-reset clear sweep.
module regfile_mp
    import otter_rf_pkg::*;
#(
    parameter  int unsigned XLEN   = RF_XLEN,
    parameter  int unsigned NREGS  = RF_NREGS,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data
);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            fwd_en;
    logic [AW-1:0]   ra;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN:  state_d = RF_RUN;
            default: state_d = RF_CLEAR;
        endcase
    end

    // The sweep owns the write port until RUN, so writebacks during it are dropped.
    always_comb begin
        ready     = (state_q == RF_RUN);
        mem_we    = 1'b0;
        mem_waddr = wb_addr;
        mem_wdata = wb_data;
        if (state_q == RF_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wb_en && (wb_addr != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fwd_en = (BYPASS != 0) && ready && wb_en;

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = AW'(field_get(FIELD_VEC_W'(rd_addr), AW, i));
            if (ra == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (fwd_en && (wb_addr == ra)) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = mem_q[ra];
            end
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default configuration with bypass, and a 16x64 four-port configuration without bypass.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   ra [4];
    logic         wb_en_a;
    logic         wb_en_b;
    logic [4:0]   wb_addr;
    logic [63:0]  wb_data;
    logic         rsv_en;
    logic [4:0]   rsv_addr;

    logic [9:0]   rd_addr_a;
    logic [15:0]  rd_addr_b;
    logic         ready_a;
    logic         ready_b;
    logic [63:0]  rd_data_a;
    logic [255:0] rd_data_b;
    logic [1:0]   rd_busy_a;
    logic [3:0]   rd_busy_b;

    logic [63:0]  exp_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    int           first_a;
    int           first_b;

    assign rd_addr_a = {ra[1], ra[0]};
    assign rd_addr_b = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN   (32),
        .NREGS  (32),
        .NREAD  (2),
        .BYPASS (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready_a),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wb_en    (wb_en_a),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data[31:0])
    );

    regfile_mp #(
        .XLEN   (64),
        .NREGS  (16),
        .NREAD  (4),
        .BYPASS (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready_b),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr[3:0]),
        .wb_en    (wb_en_b),
        .wb_addr  (wb_addr[3:0]),
        .wb_data  (wb_data)
    );

    function automatic logic [63:0] rda(input int i);
        return {32'd0, rd_data_a[i*32 +: 32]};
    endfunction

    function automatic logic [63:0] rdb(input int i);
        return rd_data_b[i*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [63:0] d);
        wb_en_a = en;
        wb_en_b = en;
        wb_addr = a;
        wb_data = d;
    endtask

    // Counts cycles from rst release until each instance raises ready, dropping its wb_en then.
    task automatic count_sweep();
        first_a = -1;
        first_b = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (ready_a && first_a < 0) begin
                first_a = c;
                wb_en_a = 1'b0;
            end
            if (ready_b && first_b < 0) begin
                first_b = c;
                wb_en_b = 1'b0;
            end
            if (first_a >= 0 && first_b >= 0) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) ra[i] = '0;
        set_wb(1'b0, 5'd0, 64'd0);
        rsv_en   = 1'b0;
        rsv_addr = '0;
        repeat (2) tick();

        expect_v(64'd0); expect_v(64'd0);
        ra[0] = 5'd3;
        #1;
        cmp("rst_ready_a", {63'd0, ready_a});
        cmp("rst_ready_b", {63'd0, ready_b});
        expect_v(64'd0); expect_v(64'd0);
        cmp("rst_busy_a", {63'd0, rd_busy_a[0]});
        cmp("rst_busy_b", {63'd0, rd_busy_b[0]});

        // Clear sweep with a writeback held on r5 throughout.
        set_wb(1'b1, 5'd5, 64'hDEAD);
        ra[0] = 5'd5;
        rst   = 1'b0;
        expect_v(64'd32); expect_v(64'd16);
        count_sweep();
        cmp("sweep_len_a", 64'(first_a));
        cmp("sweep_len_b", 64'(first_b));
        wb_en_a = 1'b0;
        wb_en_b = 1'b0;
        expect_v(64'd0); expect_v(64'd0);
        #1;
        cmp("sweep_drop_a", rda(0));
        cmp("sweep_drop_b", rdb(0));

        // Write r7, read back on every port.
        tick();
        set_wb(1'b1, 5'd7, 64'h0123_4567_1234_5678);
        expect_v(64'h1234_5678); expect_v(64'h1234_5678);
        for (int i = 0; i < 4; i++) expect_v(64'h0123_4567_1234_5678);
        tick();
        set_wb(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 4; i++) ra[i] = 5'd7;
        #1;
        cmp("r7_a0", rda(0));
        cmp("r7_a1", rda(1));
        cmp("r7_b0", rdb(0));
        cmp("r7_b1", rdb(1));
        cmp("r7_b2", rdb(2));
        cmp("r7_b3", rdb(3));

        // Write to r0 is ignored, including during the writeback cycle.
        set_wb(1'b1, 5'd0, '1);
        ra[0] = 5'd0;
        expect_v(64'd0); expect_v(64'd0);
        #1;
        cmp("x0_same_a", rda(0));
        cmp("x0_same_b", rdb(0));
        expect_v(64'd0); expect_v(64'd0);
        tick();
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        cmp("x0_after_a", rda(0));
        cmp("x0_after_b", rdb(0));

        // Bypass on a busy r9.
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0;
        set_wb(1'b1, 5'd9, 64'h1111_2222_CAFE_F00D);
        ra[0] = 5'd9;
        expect_v(64'hCAFE_F00D); expect_v(64'd0);
        expect_v(64'd0);         expect_v(64'd1);
        #1;
        cmp("byp_data_a", rda(0));
        cmp("byp_busy_a", {63'd0, rd_busy_a[0]});
        cmp("byp_data_b", rdb(0));
        cmp("byp_busy_b", {63'd0, rd_busy_b[0]});
        expect_v(64'hCAFE_F00D); expect_v(64'h1111_2222_CAFE_F00D);
        expect_v(64'd0);         expect_v(64'd0);
        tick();
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        cmp("byp_after_data_a", rda(0));
        cmp("byp_after_data_b", rdb(0));
        cmp("byp_after_busy_a", {63'd0, rd_busy_a[0]});
        cmp("byp_after_busy_b", {63'd0, rd_busy_b[0]});

        // Reserve r3, then release it by writeback.
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        ra[1]    = 5'd3;
        expect_v(64'd0);
        #1;
        cmp("rsv_pre_busy_a", {63'd0, rd_busy_a[1]});
        expect_v(64'd1); expect_v(64'd1);
        tick();
        rsv_en = 1'b0;
        #1;
        cmp("rsv_busy_a", {63'd0, rd_busy_a[1]});
        cmp("rsv_busy_b", {63'd0, rd_busy_b[1]});
        set_wb(1'b1, 5'd3, 64'h55);
        expect_v(64'd0); expect_v(64'd1);
        expect_v(64'h55); expect_v(64'd0);
        #1;
        cmp("wb3_busy_a", {63'd0, rd_busy_a[1]});
        cmp("wb3_busy_b", {63'd0, rd_busy_b[1]});
        cmp("wb3_data_a", rda(1));
        cmp("wb3_data_b", rdb(1));
        expect_v(64'd0);  expect_v(64'd0);
        expect_v(64'h55); expect_v(64'h55);
        tick();
        set_wb(1'b0, 5'd0, 64'd0);
        #1;
        cmp("rel3_busy_a", {63'd0, rd_busy_a[1]});
        cmp("rel3_busy_b", {63'd0, rd_busy_b[1]});
        cmp("rel3_data_a", rda(1));
        cmp("rel3_data_b", rdb(1));

        // Reserve and writeback r4 in the same cycle: reservation wins, data lands.
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        set_wb(1'b1, 5'd4, 64'h77);
        expect_v(64'd1); expect_v(64'd1); expect_v(64'd1); expect_v(64'd0);
        expect_v(64'h77); expect_v(64'h77);
        tick();
        rsv_en = 1'b0;
        set_wb(1'b0, 5'd0, 64'd0);
        ra[0] = 5'd4;
        ra[2] = 5'd4;
        ra[3] = 5'd0;
        #1;
        cmp("sim4_busy_a0", {63'd0, rd_busy_a[0]});
        cmp("sim4_busy_b0", {63'd0, rd_busy_b[0]});
        cmp("sim4_busy_b2", {63'd0, rd_busy_b[2]});
        cmp("sim4_busy_b3", {63'd0, rd_busy_b[3]});
        cmp("sim4_data_a0", rda(0));
        cmp("sim4_data_b2", rdb(2));

        // Reserving r0 has no effect.
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        expect_v(64'd0); expect_v(64'd0); expect_v(64'd0);
        tick();
        rsv_en = 1'b0;
        ra[1]  = 5'd0;
        #1;
        cmp("rsv0_busy_a1", {63'd0, rd_busy_a[1]});
        cmp("rsv0_busy_b3", {63'd0, rd_busy_b[3]});
        cmp("rsv0_data_a1", rda(1));

        // Reset again, then interrupt the sweep at cycle 10.
        rst = 1'b1;
        expect_v(64'd0); expect_v(64'd0);
        #1;
        cmp("rst2_ready_a", {63'd0, ready_a});
        cmp("rst2_ready_b", {63'd0, ready_b});
        tick();
        rst = 1'b0;
        repeat (10) tick();
        expect_v(64'd0); expect_v(64'd0);
        cmp("mid_ready_a", {63'd0, ready_a});
        cmp("mid_ready_b", {63'd0, ready_b});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v(64'd32); expect_v(64'd16);
        count_sweep();
        cmp("resweep_len_a", 64'(first_a));
        cmp("resweep_len_b", 64'(first_b));
        expect_v(64'd0); expect_v(64'd0);
        #1;
        cmp("resweep_busy4_a", {63'd0, rd_busy_a[0]});
        cmp("resweep_busy4_b", {63'd0, rd_busy_b[0]});

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected values never compared", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
